// File: rtl/rv32_pkg.sv
// rv32_pkg: shared RV32 types and helpers for the load/store unit.
// Provides the access-size and LSU FSM enums plus byte-enable, store-lane and
// alignment helpers so a future store buffer can reuse the same encodings.
package rv32_pkg;

    typedef enum logic [1:0] {lsu_byte, lsu_half, lsu_word} lsu_type_e;

    typedef enum logic [1:0] {LSU_IDLE, LSU_WAIT_GNT, LSU_WAIT_RVALID} lsu_state_e;

    function automatic logic [3:0] lsu_be(input lsu_type_e t, input logic [1:0] off);
        return t == lsu_byte ? 4'b0001 << off : t == lsu_half ? 4'b0011 << off : 4'b1111;
    endfunction

    // Replicate the right-aligned store value across every lane it may land in.
    function automatic logic [31:0] lsu_wdata(input lsu_type_e t, input logic [31:0] wd);
        return t == lsu_byte ? {4{wd[7:0]}} : t == lsu_half ? {2{wd[15:0]}} : wd;
    endfunction

    function automatic logic lsu_misaligned(input lsu_type_e t, input logic [1:0] off);
        return t == lsu_byte ? 1'b0 : t == lsu_half ? off[0] : |off;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational load-lane extraction and sign/zero extension.
// Ports: rdata_i full response word, off_i byte offset, type_i access size,
// sign_ext_i extend mode, data_o right-aligned extended result.
module lsu_align
    import rv32_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  off_i,
    input  lsu_type_e   type_i,
    input  logic        sign_ext_i,
    output logic [31:0] data_o
);
    logic [7:0]  b;
    logic [15:0] h;

    assign b = rdata_i[{off_i, 3'b000} +: 8];
    assign h = rdata_i[{off_i[1], 4'b0000} +: 16];

    always_comb begin
        data_o = type_i == lsu_byte ? {{24{sign_ext_i & b[7]}}, b}
               : type_i == lsu_half ? {{16{sign_ext_i & h[15]}}, h}
               : rdata_i;
    end
endmodule

// File: rtl/lsu.sv
// lsu: RV32 load/store unit driving a req/gnt/rvalid data-memory port.
// Ports: clk_i/rst_i (async active-high); req_i, we_i, type_i, sign_ext_i,
// addr_i, wdata_i from execute; busy_o, rvalid_o, rdata_o, misaligned_o to
// writeback; data_* memory port. Define LSU_BUS_ERR_EN to add data_err_i/err_o.
module lsu
    import rv32_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        we_i,
    input  lsu_type_e   type_i,
    input  logic        sign_ext_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        busy_o,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        misaligned_o,
    output logic        data_req_o,
    input  logic        data_gnt_i,
    output logic [31:0] data_addr_o,
    output logic        data_we_o,
    output logic [3:0]  data_be_o,
    output logic [31:0] data_wdata_o,
    input  logic        data_rvalid_i,
`ifdef LSU_BUS_ERR_EN
    input  logic        data_err_i,
    output logic        err_o,
`endif
    input  logic [31:0] data_rdata_i
);
    lsu_state_e  state_q, state_d;
    logic [1:0]  off_q, off_d;
    logic        we_q, we_d, sext_q, sext_d;
    lsu_type_e   type_q, type_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d, load_data;
    logic [3:0]  be_q, be_d;
    logic        req_q, req_d, rvalid_q, rvalid_d, mis_q, mis_d, fail;
`ifdef LSU_BUS_ERR_EN
    logic        err_q, err_d;
    assign fail  = data_err_i;
    assign err_o = err_q;
`else
    assign fail  = 1'b0;
`endif

    lsu_align u_align (
        .rdata_i    (data_rdata_i),
        .off_i      (off_q),
        .type_i     (type_q),
        .sign_ext_i (sext_q),
        .data_o     (load_data)
    );

    assign busy_o       = state_q != LSU_IDLE;
    assign rvalid_o     = rvalid_q;
    assign rdata_o      = rdata_q;
    assign misaligned_o = mis_q;
    assign data_req_o   = req_q;
    assign data_addr_o  = addr_q;
    assign data_we_o    = we_q;
    assign data_be_o    = be_q;
    assign data_wdata_o = wdata_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= LSU_IDLE;
            off_q    <= '0;
            we_q     <= 1'b0;
            sext_q   <= 1'b0;
            type_q   <= lsu_byte;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            be_q     <= '0;
            req_q    <= 1'b0;
            rvalid_q <= 1'b0;
            mis_q    <= 1'b0;
`ifdef LSU_BUS_ERR_EN
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            off_q    <= off_d;
            we_q     <= we_d;
            sext_q   <= sext_d;
            type_q   <= type_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            be_q     <= be_d;
            req_q    <= req_d;
            rvalid_q <= rvalid_d;
            mis_q    <= mis_d;
`ifdef LSU_BUS_ERR_EN
            err_q    <= err_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        off_d    = off_q;
        we_d     = we_q;
        sext_d   = sext_q;
        type_d   = type_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        be_d     = be_q;
        req_d    = req_q;
        rvalid_d = 1'b0;
        rdata_d  = '0;
        mis_d    = 1'b0;
`ifdef LSU_BUS_ERR_EN
        err_d    = 1'b0;
`endif
        case (state_q)
            LSU_IDLE: begin
                if (req_i && lsu_misaligned(type_i, addr_i[1:0])) begin
                    mis_d = 1'b1;
                end else if (req_i) begin
                    off_d   = addr_i[1:0];
                    we_d    = we_i;
                    sext_d  = sign_ext_i;
                    type_d  = type_i;
                    addr_d  = {addr_i[31:2], 2'b00};
                    wdata_d = lsu_wdata(type_i, wdata_i);
                    be_d    = lsu_be(type_i, addr_i[1:0]);
                    req_d   = 1'b1;
                    state_d = LSU_WAIT_GNT;
                end
            end
            LSU_WAIT_GNT: begin
                if (data_gnt_i) begin
                    req_d   = 1'b0;
                    state_d = LSU_WAIT_RVALID;
                end
            end
            LSU_WAIT_RVALID: begin
                if (data_rvalid_i) begin
                    rvalid_d = 1'b1;
                    rdata_d  = (we_q || fail) ? 32'd0 : load_data;
`ifdef LSU_BUS_ERR_EN
                    err_d    = data_err_i;
`endif
                    state_d  = LSU_IDLE;
                end
            end
            default: state_d = LSU_IDLE;
        endcase
    end
endmodule

// File: tb/tb_lsu.sv
// tb_lsu: randomized self-checking bench for lsu against a byte-lane reference model.
module tb_lsu;
    import rv32_pkg::*;

    logic        clk, rst_i, req_i, we_i, sign_ext_i, data_gnt_i, data_rvalid_i;
    lsu_type_e   type_i;
    logic [31:0] addr_i, wdata_i, data_rdata_i;
    logic        busy_o, rvalid_o, misaligned_o, data_req_o, data_we_o;
    logic [31:0] rdata_o, data_addr_o, data_wdata_o;
    logic [3:0]  data_be_o;
`ifdef LSU_BUS_ERR_EN
    logic        data_err_i, err_o;
`endif
    int errors = 0;
    int checks = 0;

    lsu dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .req_i         (req_i),
        .we_i          (we_i),
        .type_i        (type_i),
        .sign_ext_i    (sign_ext_i),
        .addr_i        (addr_i),
        .wdata_i       (wdata_i),
        .busy_o        (busy_o),
        .rvalid_o      (rvalid_o),
        .rdata_o       (rdata_o),
        .misaligned_o  (misaligned_o),
        .data_req_o    (data_req_o),
        .data_gnt_i    (data_gnt_i),
        .data_addr_o   (data_addr_o),
        .data_we_o     (data_we_o),
        .data_be_o     (data_be_o),
        .data_wdata_o  (data_wdata_o),
        .data_rvalid_i (data_rvalid_i),
`ifdef LSU_BUS_ERR_EN
        .data_err_i    (data_err_i),
        .err_o         (err_o),
`endif
        .data_rdata_i  (data_rdata_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int size_of(input logic [1:0] t);
        return t == 2'd0 ? 1 : t == 2'd1 ? 2 : 4;
    endfunction

    function automatic logic [3:0] model_be(input logic [1:0] t, input logic [31:0] a);
        int s = size_of(t);
        logic [3:0] r = 4'd0;
        for (int i = 0; i < s; i++) r[(a % 4) + i] = 1'b1;
        return r;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [1:0] t, input logic [31:0] wd);
        int s = size_of(t);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % s) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] model_load(input logic [1:0] t, input logic sx, input logic [31:0] a, input logic [31:0] rd);
        int s = size_of(t);
        logic [31:0] v = rd >> (8 * (a % 4));
        logic [31:0] m = s == 4 ? 32'hFFFF_FFFF : (32'd1 << (8 * s)) - 1;
        v = v & m;
        if (sx && s < 4 && v[8*s-1]) v = v | ~m;
        return v;
    endfunction

    // One complete transaction from an idle unit; returns in the cycle rvalid_o/misaligned_o is seen.
    task automatic do_txn(input logic w, input logic [1:0] t, input logic sx, input logic [31:0] a,
                          input logic [31:0] wd, input int gd, input logic [31:0] rd, input int rdl,
                          input logic e);
        logic [31:0] exp_rd;
        req_i = 1'b1; we_i = w; type_i = lsu_type_e'(t); sign_ext_i = sx; addr_i = a; wdata_i = wd;
        step();
        req_i = 1'b0; addr_i = $urandom; wdata_i = $urandom; we_i = ~w;
        if (a % size_of(t) != 0) begin
            checks++; if (misaligned_o !== 1'b1) begin errors++; $display("FAIL mis_pulse a=%h got=%b exp=1", a, misaligned_o); end
            checks++; if (data_req_o !== 1'b0) begin errors++; $display("FAIL mis_noreq got=%b exp=0", data_req_o); end
            checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL mis_busy got=%b exp=0", busy_o); end
            step();
            checks++; if (misaligned_o !== 1'b0) begin errors++; $display("FAIL mis_once got=%b exp=0", misaligned_o); end
            checks++; if ({data_req_o, busy_o} !== 2'b00) begin errors++; $display("FAIL mis_idle got=%b exp=00", {data_req_o, busy_o}); end
            return;
        end
        for (int k = 0; k <= gd; k++) begin
            checks++; if (data_req_o !== 1'b1 || busy_o !== 1'b1) begin errors++; $display("FAIL req_held k=%0d req=%b busy=%b exp=1,1", k, data_req_o, busy_o); end
            checks++; if (data_addr_o !== {a[31:2], 2'b00}) begin errors++; $display("FAIL addr got=%h exp=%h", data_addr_o, {a[31:2], 2'b00}); end
            checks++; if (data_be_o !== model_be(t, a)) begin errors++; $display("FAIL be got=%b exp=%b", data_be_o, model_be(t, a)); end
            checks++; if (data_we_o !== w) begin errors++; $display("FAIL we got=%b exp=%b", data_we_o, w); end
            if (w) begin
                checks++; if (data_wdata_o !== model_wdata(t, wd)) begin errors++; $display("FAIL wdata got=%h exp=%h", data_wdata_o, model_wdata(t, wd)); end
            end
            data_gnt_i = (k == gd);
            step();
        end
        data_gnt_i = 1'b0;
        checks++; if (data_req_o !== 1'b0) begin errors++; $display("FAIL req_drop got=%b exp=0", data_req_o); end
        for (int k = 0; k < rdl; k++) begin
            step();
            checks++; if (rvalid_o !== 1'b0 || busy_o !== 1'b1) begin errors++; $display("FAIL wait_rv rvalid=%b busy=%b exp=0,1", rvalid_o, busy_o); end
        end
        data_rvalid_i = 1'b1; data_rdata_i = rd;
`ifdef LSU_BUS_ERR_EN
        data_err_i = e;
`endif
        step();
        data_rvalid_i = 1'b0; data_rdata_i = $urandom;
`ifdef LSU_BUS_ERR_EN
        data_err_i = 1'b0;
`endif
        exp_rd = (w || e) ? 32'd0 : model_load(t, sx, a, rd);
        checks++; if (rvalid_o !== 1'b1) begin errors++; $display("FAIL rvalid got=%b exp=1", rvalid_o); end
        checks++; if (rdata_o !== exp_rd) begin errors++; $display("FAIL rdata a=%h t=%0d got=%h exp=%h", a, t, rdata_o, exp_rd); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL done_busy got=%b exp=0", busy_o); end
`ifdef LSU_BUS_ERR_EN
        checks++; if (err_o !== e) begin errors++; $display("FAIL err got=%b exp=%b", err_o, e); end
`endif
    endtask

    task automatic test_reset();
        rst_i = 1'b1; req_i = 1'b0; we_i = 1'b0; type_i = lsu_byte; sign_ext_i = 1'b0;
        addr_i = '0; wdata_i = '0; data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_rdata_i = '0;
`ifdef LSU_BUS_ERR_EN
        data_err_i = 1'b0;
`endif
        step(); step();
        checks++; if ({busy_o, rvalid_o, misaligned_o, data_req_o, data_we_o} !== 5'b0) begin errors++; $display("FAIL reset_ctrl got=%b exp=0", {busy_o, rvalid_o, misaligned_o, data_req_o, data_we_o}); end
        checks++; if ({rdata_o, data_addr_o, data_wdata_o, data_be_o} !== '0) begin errors++; $display("FAIL reset_data got=%h exp=0", {rdata_o, data_addr_o, data_wdata_o, data_be_o}); end
`ifdef LSU_BUS_ERR_EN
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", err_o); end
`endif
        rst_i = 1'b0;
        step();
    endtask

    task automatic test_directed();
        do_txn(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 0, 32'hDEADBEEF, 0, 1'b0);
        checks++; if (rdata_o !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_const got=%h exp=deadbeef", rdata_o); end
        do_txn(1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 0, 32'h80112233, 1, 1'b0);
        checks++; if (rdata_o !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_const got=%h exp=ffffff80", rdata_o); end
        do_txn(1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 1, 32'h80112233, 0, 1'b0);
        checks++; if (rdata_o !== 32'h00000080) begin errors++; $display("FAIL lbu_const got=%h exp=00000080", rdata_o); end
        do_txn(1'b1, 2'd1, 1'b0, 32'h202, 32'h1234ABCD, 3, 32'h55AA55AA, 2, 1'b0);
        checks++; if (rdata_o !== 32'h0) begin errors++; $display("FAIL sh_rdata got=%h exp=0", rdata_o); end
    endtask

    task automatic test_misaligned();
        step();
        do_txn(1'b0, 2'd2, 1'b0, 32'h101, 32'h0, 0, 32'h0, 0, 1'b0);
        do_txn(1'b0, 2'd1, 1'b1, 32'h003, 32'h0, 0, 32'h0, 0, 1'b0);
    endtask

    task automatic test_stray_rvalid();
        data_rvalid_i = 1'b1; data_rdata_i = 32'hCAFEF00D;
        step(); step();
        data_rvalid_i = 1'b0;
        checks++; if (rvalid_o !== 1'b0 || busy_o !== 1'b0) begin errors++; $display("FAIL stray_rvalid rvalid=%b busy=%b exp=0,0", rvalid_o, busy_o); end
    endtask

    task automatic test_reset_mid();
        req_i = 1'b1; we_i = 1'b1; type_i = lsu_word; addr_i = 32'h440; wdata_i = 32'h11223344;
        step();
        req_i = 1'b0;
        checks++; if (data_req_o !== 1'b1) begin errors++; $display("FAIL rstg_pre got=%b exp=1", data_req_o); end
        rst_i = 1'b1; #1;
        checks++; if ({data_req_o, busy_o, data_addr_o, data_we_o} !== '0) begin errors++; $display("FAIL rst_wait_gnt req=%b busy=%b addr=%h exp=0", data_req_o, busy_o, data_addr_o); end
        step(); rst_i = 1'b0; step();
        req_i = 1'b1; we_i = 1'b0; type_i = lsu_word; addr_i = 32'h40;
        step();
        req_i = 1'b0; data_gnt_i = 1'b1;
        step();
        data_gnt_i = 1'b0;
        checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL rstr_pre got=%b exp=1", busy_o); end
        rst_i = 1'b1; #1;
        checks++; if ({data_req_o, busy_o, rvalid_o} !== 3'b0) begin errors++; $display("FAIL rst_wait_rv got=%b exp=000", {data_req_o, busy_o, rvalid_o}); end
        step(); rst_i = 1'b0; step();
        data_rvalid_i = 1'b1; data_rdata_i = 32'h12345678;
        step();
        data_rvalid_i = 1'b0;
        checks++; if (rvalid_o !== 1'b0 || busy_o !== 1'b0) begin errors++; $display("FAIL late_rvalid rvalid=%b busy=%b exp=0,0", rvalid_o, busy_o); end
        step();
        checks++; if (rvalid_o !== 1'b0) begin errors++; $display("FAIL late_rvalid2 got=%b exp=0", rvalid_o); end
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 60; n++) begin
            logic [1:0] t = 2'($urandom_range(0, 2));
            logic [31:0] a = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'(a[1:0] & ~(size_of(t) - 1));
            do_txn(1'($urandom), t, 1'($urandom), a, $urandom, $urandom_range(0, 3), $urandom, $urandom_range(0, 2), 1'b0);
        end
    endtask

`ifdef LSU_BUS_ERR_EN
    task automatic test_bus_err();
        do_txn(1'b0, 2'd2, 1'b0, 32'h300, 32'h0, 1, 32'hFFFFFFFF, 0, 1'b1);
        do_txn(1'b1, 2'd0, 1'b0, 32'h301, 32'hA5, 0, 32'h0, 1, 1'b1);
        do_txn(1'b0, 2'd2, 1'b0, 32'h304, 32'h0, 0, 32'h0BADF00D, 0, 1'b0);
        checks++; if (rdata_o !== 32'h0BADF00D) begin errors++; $display("FAIL err_recover got=%h exp=0badf00d", rdata_o); end
    endtask
`endif

    initial begin
        test_reset();
        test_directed();
        test_misaligned();
        test_stray_rvalid();
        test_reset_mid();
        test_back_to_back();
`ifdef LSU_BUS_ERR_EN
        test_bus_err();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
